// File: rtl/axil_reg_responder.sv
// AXI-Lite register responder: control/status register bank with independent write and read channels.
// Define AXIL_WSTRB_EN to honour w_strb byte lanes; otherwise every write replaces the whole word.
module axil_reg_responder #(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = 32'hBA5A_0001
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   aw_addr,
  input  logic                          aw_valid,
  output logic                          aw_ready,
  input  logic [31:0]                   w_data,
  input  logic [3:0]                    w_strb,
  input  logic                          w_valid,
  output logic                          w_ready,
  output logic [1:0]                    b_resp,
  output logic                          b_valid,
  input  logic                          b_ready,
  input  logic [31:0]                   ar_addr,
  input  logic                          ar_valid,
  output logic                          ar_ready,
  output logic [31:0]                   r_data,
  output logic [1:0]                    r_resp,
  output logic                          r_valid,
  input  logic                          r_ready,
  output logic [NUM_REGS*32-1:0]        regs_o,
  input  logic [31:0]                   status_i,
  output logic                          wr_pulse_o,
  output logic [$clog2(NUM_REGS)-1:0]   wr_idx_o
);

  localparam int         IDXW        = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  function automatic logic [IDXW-1:0] addr_idx(input logic [31:0] addr);
    return addr[IDXW+1:2];
  endfunction

  function automatic logic addr_oor(input logic [31:0] addr);
    return (addr >> (IDXW + 2)) != 32'd0;
  endfunction

`ifdef AXIL_WSTRB_EN
  function automatic logic [31:0] apply_strb(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] mask;
    for (int k = 0; k < 4; k++) begin
      mask[8*k +: 8] = {8{strb[k]}};
    end
    return (old_word & ~mask) | (new_word & mask);
  endfunction
`endif

  logic [31:0]     r_regs [NUM_REGS];

  wstate_t         r_wstate;
  wstate_t         w_wstate_nxt;
  logic            r_aw_ready;
  logic            r_w_ready;
  logic            r_b_valid;
  logic [1:0]      r_b_resp;
  logic            r_aw_held;
  logic            r_w_held;
  logic [IDXW-1:0] r_aw_idx;
  logic            r_aw_oor;
  logic [31:0]     r_wbeat_data;
  logic            r_wr_pulse;
  logic [IDXW-1:0] r_wr_idx;

  logic            w_aw_ready_nxt;
  logic            w_w_ready_nxt;
  logic            w_b_valid_nxt;
  logic            w_aw_held_nxt;
  logic            w_w_held_nxt;

  logic            w_aw_hs;
  logic            w_w_hs;
  logic            w_b_hs;
  logic            w_aw_have;
  logic            w_w_have;
  logic            w_commit;
  logic            w_wr_legal;
  logic            w_wr_ok;
  logic [IDXW-1:0] w_wr_idx;
  logic            w_wr_oor;
  logic [31:0]     w_wr_data;
  logic [31:0]     w_wr_word;

  rstate_t         r_rstate;
  rstate_t         w_rstate_nxt;
  logic            r_ar_ready;
  logic            r_r_valid;
  logic [31:0]     r_r_data;
  logic [1:0]      r_r_resp;
  logic            w_ar_ready_nxt;
  logic            w_r_valid_nxt;
  logic            w_ar_hs;
  logic            w_r_hs;
  logic [IDXW-1:0] w_rd_idx;
  logic [31:0]     w_rd_data;
  logic [1:0]      w_rd_resp;

  // A beat arriving on the commit edge is used directly, so the response follows the last handshake by one cycle.
  assign w_aw_hs    = aw_valid & r_aw_ready;
  assign w_w_hs     = w_valid & r_w_ready;
  assign w_b_hs     = r_b_valid & b_ready;
  assign w_aw_have  = r_aw_held | w_aw_hs;
  assign w_w_have   = r_w_held | w_w_hs;
  assign w_commit   = (r_wstate == W_IDLE) & w_aw_have & w_w_have;
  assign w_wr_idx   = w_aw_hs ? addr_idx(aw_addr) : r_aw_idx;
  assign w_wr_oor   = w_aw_hs ? addr_oor(aw_addr) : r_aw_oor;
  assign w_wr_data  = w_w_hs ? w_data : r_wbeat_data;
  assign w_wr_legal = ~w_wr_oor & (w_wr_idx > IDXW'(1));
  assign w_wr_ok    = w_commit & w_wr_legal;

`ifdef AXIL_WSTRB_EN
  logic [3:0] r_wbeat_strb;
  logic [3:0] w_wr_strb;

  assign w_wr_strb = w_w_hs ? w_strb : r_wbeat_strb;
  assign w_wr_word = apply_strb(r_regs[w_wr_idx], w_wr_data, w_wr_strb);

  // Strobe capture for a W beat that arrives ahead of its address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbeat_strb <= 4'd0;
    end else if (w_w_hs) begin
      r_wbeat_strb <= w_strb;
    end
  end
`else
  logic w_unused_strb;

  assign w_unused_strb = ^w_strb;
  assign w_wr_word     = w_wr_data;
`endif

  // Write channel next-state and next-handshake logic.
  always_comb begin
    w_wstate_nxt   = r_wstate;
    w_aw_ready_nxt = r_aw_ready;
    w_w_ready_nxt  = r_w_ready;
    w_b_valid_nxt  = r_b_valid;
    w_aw_held_nxt  = r_aw_held;
    w_w_held_nxt   = r_w_held;
    case (r_wstate)
      W_IDLE: begin
        if (w_commit) begin
          w_wstate_nxt   = W_RESP;
          w_aw_ready_nxt = 1'b0;
          w_w_ready_nxt  = 1'b0;
          w_b_valid_nxt  = 1'b1;
          w_aw_held_nxt  = 1'b1;
          w_w_held_nxt   = 1'b1;
        end else begin
          w_aw_ready_nxt = ~w_aw_have;
          w_w_ready_nxt  = ~w_w_have;
          w_aw_held_nxt  = w_aw_have;
          w_w_held_nxt   = w_w_have;
        end
      end
      W_RESP: begin
        if (w_b_hs) begin
          w_wstate_nxt   = W_IDLE;
          w_aw_ready_nxt = 1'b1;
          w_w_ready_nxt  = 1'b1;
          w_b_valid_nxt  = 1'b0;
          w_aw_held_nxt  = 1'b0;
          w_w_held_nxt   = 1'b0;
        end else begin
          w_wstate_nxt   = W_RESP;
        end
      end
      default: begin
        w_wstate_nxt   = W_IDLE;
        w_aw_ready_nxt = 1'b1;
        w_w_ready_nxt  = 1'b1;
        w_b_valid_nxt  = 1'b0;
        w_aw_held_nxt  = 1'b0;
        w_w_held_nxt   = 1'b0;
      end
    endcase
  end

  // Write channel state, handshake and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate   <= W_IDLE;
      r_aw_ready <= 1'b1;
      r_w_ready  <= 1'b1;
      r_b_valid  <= 1'b0;
      r_b_resp   <= RESP_OKAY;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_wr_idx   <= '0;
    end else begin
      r_wstate   <= w_wstate_nxt;
      r_aw_ready <= w_aw_ready_nxt;
      r_w_ready  <= w_w_ready_nxt;
      r_b_valid  <= w_b_valid_nxt;
      r_aw_held  <= w_aw_held_nxt;
      r_w_held   <= w_w_held_nxt;
      r_wr_pulse <= w_wr_ok;
      if (w_commit) begin
        r_b_resp <= w_wr_legal ? RESP_OKAY : RESP_SLVERR;
      end
      if (w_wr_ok) begin
        r_wr_idx <= w_wr_idx;
      end
    end
  end

  // Address and data capture for beats that arrive on different cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_idx     <= '0;
      r_aw_oor     <= 1'b0;
      r_wbeat_data <= 32'd0;
    end else begin
      if (w_aw_hs) begin
        r_aw_idx <= addr_idx(aw_addr);
        r_aw_oor <= addr_oor(aw_addr);
      end
      if (w_w_hs) begin
        r_wbeat_data <= w_data;
      end
    end
  end

  // Register bank; entries 0 and 1 are never legal targets and stay zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_ok && (w_wr_idx == IDXW'(i))) begin
          r_regs[i] <= w_wr_word;
        end
      end
    end
  end

  assign w_ar_hs  = ar_valid & r_ar_ready;
  assign w_r_hs   = r_r_valid & r_ready;
  assign w_rd_idx = addr_idx(ar_addr);

  // Read data selection; a same-edge write is not visible until the next read.
  always_comb begin
    w_rd_data = 32'd0;
    w_rd_resp = RESP_OKAY;
    if (addr_oor(ar_addr)) begin
      w_rd_data = 32'd0;
      w_rd_resp = RESP_SLVERR;
    end else if (w_rd_idx == IDXW'(0)) begin
      w_rd_data = ID_VALUE;
    end else if (w_rd_idx == IDXW'(1)) begin
      w_rd_data = status_i;
    end else begin
      w_rd_data = r_regs[w_rd_idx];
    end
  end

  // Read channel next-state and next-handshake logic.
  always_comb begin
    w_rstate_nxt   = r_rstate;
    w_ar_ready_nxt = r_ar_ready;
    w_r_valid_nxt  = r_r_valid;
    case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs) begin
          w_rstate_nxt   = R_DATA;
          w_ar_ready_nxt = 1'b0;
          w_r_valid_nxt  = 1'b1;
        end else begin
          w_rstate_nxt   = R_IDLE;
          w_ar_ready_nxt = 1'b1;
        end
      end
      R_DATA: begin
        if (w_r_hs) begin
          w_rstate_nxt   = R_IDLE;
          w_ar_ready_nxt = 1'b1;
          w_r_valid_nxt  = 1'b0;
        end else begin
          w_rstate_nxt   = R_DATA;
        end
      end
      default: begin
        w_rstate_nxt   = R_IDLE;
        w_ar_ready_nxt = 1'b1;
        w_r_valid_nxt  = 1'b0;
      end
    endcase
  end

  // Read channel state, handshake and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate   <= R_IDLE;
      r_ar_ready <= 1'b1;
      r_r_valid  <= 1'b0;
      r_r_data   <= 32'd0;
      r_r_resp   <= RESP_OKAY;
    end else begin
      r_rstate   <= w_rstate_nxt;
      r_ar_ready <= w_ar_ready_nxt;
      r_r_valid  <= w_r_valid_nxt;
      if (w_ar_hs) begin
        r_r_data <= w_rd_data;
        r_r_resp <= w_rd_resp;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_o[32*g +: 32] = r_regs[g];
  end

  assign aw_ready   = r_aw_ready;
  assign w_ready    = r_w_ready;
  assign b_valid    = r_b_valid;
  assign b_resp     = r_b_resp;
  assign ar_ready   = r_ar_ready;
  assign r_valid    = r_r_valid;
  assign r_data     = r_r_data;
  assign r_resp     = r_r_resp;
  assign wr_pulse_o = r_wr_pulse;
  assign wr_idx_o   = r_wr_idx;

endmodule

// File: tb/tb_axil_reg_responder.sv
// Randomized bench for axil_reg_responder: a register-array reference model feeds response
// queues that an independent monitor drains on every B/R handshake and write pulse.
module tb_axil_reg_responder;
  localparam int          NUM_REGS = 16;
  localparam int          IDXW     = $clog2(NUM_REGS);
  localparam logic [31:0] ID_VALUE = 32'hBA5A_0001;

  logic clk, rst_n;
  logic [31:0] aw_addr, w_data, ar_addr, r_data, status_i;
  logic aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic ar_valid, ar_ready, r_valid, r_ready, wr_pulse_o;
  logic [3:0] w_strb;
  logic [1:0] b_resp, r_resp;
  logic [NUM_REGS*32-1:0] regs_o;
  logic [IDXW-1:0] wr_idx_o;

  axil_reg_responder #(.NUM_REGS(NUM_REGS), .ID_VALUE(ID_VALUE)) dut (
    .clk(clk), .rst_n(rst_n),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .regs_o(regs_o), .status_i(status_i),
    .wr_pulse_o(wr_pulse_o), .wr_idx_o(wr_idx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic [1:0] resp; logic [NUM_REGS*32-1:0] regs;} bexp_t;
  typedef struct {logic [1:0] resp; logic [31:0] data;} rexp_t;

  bexp_t bq[$];
  rexp_t rq[$];
  int    pq[$];
  logic [31:0] model [NUM_REGS];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [NUM_REGS*32-1:0] act, input logic [NUM_REGS*32-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_REGS*32-1:0] model_flat();
    logic [NUM_REGS*32-1:0] v;
    for (int i = 0; i < NUM_REGS; i++) v[32*i +: 32] = (i < 2) ? 32'd0 : model[i];
    return v;
  endfunction

  function automatic bit legal_write(input logic [31:0] addr);
    return (addr < NUM_REGS*4) && (addr >= 32'd8);
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bexp_t e;
    int idx;
    idx = int'(addr / 4);
    if (legal_write(addr)) begin
`ifdef AXIL_WSTRB_EN
      for (int k = 0; k < 4; k++) if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
`else
      logic [3:0] unused_strb;
      unused_strb = strb;
      model[idx] = data;
`endif
      e.resp = 2'b00;
      pq.push_back(idx);
    end else begin
      e.resp = 2'b10;
    end
    e.regs = model_flat();
    bq.push_back(e);
  endtask

  function automatic rexp_t model_read(input logic [31:0] addr);
    rexp_t e;
    e.resp = 2'b00;
    if (addr >= NUM_REGS*4) begin
      e.data = 32'd0;
      e.resp = 2'b10;
    end else if (addr / 4 == 0) e.data = ID_VALUE;
    else if (addr / 4 == 1)     e.data = status_i;
    else                        e.data = model[addr / 4];
    return e;
  endfunction

  // Monitor: pops expectations whenever the DUT completes a response handshake or pulses a write.
  always @(negedge clk) begin : mon
    bexp_t be;
    rexp_t re;
    int pi;
    if (rst_n) begin
      if (b_valid && b_ready) begin
        if (bq.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
        else begin
          be = bq.pop_front();
          chk("b_resp", 32'(b_resp), 32'(be.resp));
          chkw("regs_o", regs_o, be.regs);
        end
      end
      if (r_valid && r_ready) begin
        if (rq.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
        else begin
          re = rq.pop_front();
          chk("r_data", r_data, re.data);
          chk("r_resp", 32'(r_resp), 32'(re.resp));
        end
      end
      if (wr_pulse_o) begin
        if (pq.size() == 0) chk("wr_pulse_unexpected", 32'd1, 32'd0);
        else begin
          pi = pq.pop_front();
          chk("wr_idx", 32'(wr_idx_o), 32'(pi));
        end
      end
    end
  end

  // gap > 0: AW leads W by gap cycles; gap < 0: W leads AW.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int gap, input int bdly);
    bit aw_pend, w_pend, aw_fire, w_fire, fire;
    int aw_start, w_start, c;
    logic [1:0] exp_resp;
    exp_resp = legal_write(addr) ? 2'b00 : 2'b10;
    model_write(addr, data, strb);
    aw_pend = 1'b1; w_pend = 1'b1; c = 0;
    aw_start = (gap < 0) ? -gap : 0;
    w_start  = (gap > 0) ? gap : 0;
    aw_addr = addr; w_data = data; w_strb = strb;
    while ((aw_pend || w_pend) && c < 50) begin
      aw_valid = aw_pend && (c >= aw_start);
      w_valid  = w_pend && (c >= w_start);
      @(negedge clk);
      chk("b_valid_early", 32'(b_valid), 32'd0);
      if (!aw_pend) chk("aw_ready_after_capture", 32'(aw_ready), 32'd0);
      if (!w_pend)  chk("w_ready_after_capture", 32'(w_ready), 32'd0);
      aw_fire = aw_valid && aw_ready;
      w_fire  = w_valid && w_ready;
      @(posedge clk); #1;
      if (aw_fire) aw_pend = 1'b0;
      if (w_fire)  w_pend = 1'b0;
      c++;
    end
    aw_valid = 1'b0; w_valid = 1'b0;
    if (aw_pend || w_pend) begin
      chk("write_hs_timeout", 32'd1, 32'd0);
      return;
    end
    chk("b_valid_rise", 32'(b_valid), 32'd1);
    chk("wr_pulse_timing", 32'(wr_pulse_o), 32'(legal_write(addr)));
    repeat (bdly) begin
      @(negedge clk);
      chk("b_stall_valid", 32'(b_valid), 32'd1);
      chk("b_stall_resp", 32'(b_resp), 32'(exp_resp));
      chk("aww_ready_stall", {30'd0, aw_ready, w_ready}, 32'd0);
      @(posedge clk); #1;
    end
    b_ready = 1'b1; c = 0; fire = 1'b0;
    while (!fire && c < 20) begin
      @(negedge clk);
      fire = b_valid;
      @(posedge clk); #1;
      c++;
    end
    b_ready = 1'b0;
    if (!fire) chk("b_hs_timeout", 32'd1, 32'd0);
    else chk("aww_ready_back", {30'd0, aw_ready, w_ready}, 32'd3);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int rdly);
    rexp_t e;
    bit fire;
    int c;
    e = model_read(addr);
    rq.push_back(e);
    ar_addr = addr; ar_valid = 1'b1; c = 0; fire = 1'b0;
    while (!fire && c < 20) begin
      @(negedge clk);
      fire = ar_ready;
      @(posedge clk); #1;
      c++;
    end
    ar_valid = 1'b0;
    if (!fire) begin
      chk("ar_hs_timeout", 32'd1, 32'd0);
      return;
    end
    chk("r_valid_rise", 32'(r_valid), 32'd1);
    status_i = ~status_i;
    repeat (rdly) begin
      @(negedge clk);
      chk("r_stall_valid", 32'(r_valid), 32'd1);
      chk("r_stall_data", r_data, e.data);
      chk("r_stall_resp", 32'(r_resp), 32'(e.resp));
      chk("ar_ready_stall", 32'(ar_ready), 32'd0);
      @(posedge clk); #1;
    end
    r_ready = 1'b1; c = 0; fire = 1'b0;
    while (!fire && c < 20) begin
      @(negedge clk);
      fire = r_valid;
      @(posedge clk); #1;
      c++;
    end
    r_ready = 1'b0;
    if (!fire) chk("r_hs_timeout", 32'd1, 32'd0);
    else chk("ar_ready_back", 32'(ar_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rexp_t re;
    rst_n = 1'b0;
    aw_addr = 32'd0; aw_valid = 1'b0; w_data = 32'd0; w_strb = 4'hF; w_valid = 1'b0;
    b_ready = 1'b0; ar_addr = 32'd0; ar_valid = 1'b0; r_ready = 1'b0; status_i = 32'd0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {29'd0, aw_ready, w_ready, ar_ready}, 32'd7);
    chk("rst_valid", {30'd0, b_valid, r_valid}, 32'd0);
    chk("rst_resp", {28'd0, b_resp, r_resp}, 32'd0);
    chk("rst_r_data", r_data, 32'd0);
    chkw("rst_regs", regs_o, '0);
    chk("rst_wr", {31'd0, wr_pulse_o} | 32'(wr_idx_o), 32'd0);
    @(posedge clk); #1;

    axi_write(32'h08, 32'hCAFE_BABE, 4'hF, 0, 0);
    chk("reg2_cafe", regs_o[95:64], 32'hCAFE_BABE);
    axi_read(32'h08, 0);
    axi_read(32'h00, 1);
    status_i = 32'h1234;
    axi_read(32'h04, 0);
    axi_write(32'h00, 32'hDEAD_0000, 4'hF, 0, 0);
    axi_read(32'h00, 0);
    axi_write(32'h04, 32'h1111_1111, 4'hF, 1, 0);
    axi_write(32'h40, 32'd1, 4'hF, 0, 0);
    axi_read(32'h40, 0);
    axi_write(32'h0C, 32'h5, 4'hF, 3, 0);
    chk("reg3_aw_first", regs_o[127:96], 32'h5);
    axi_write(32'h10, 32'h6, 4'hF, -3, 0);
    axi_write(32'h14, 32'h7, 4'hF, 0, 5);
    axi_read(32'h14, 5);

    axi_write(32'h08, 32'hFFFF_FFFF, 4'hF, 0, 0);
    axi_write(32'h08, 32'h0, 4'b0101, 0, 0);
`ifdef AXIL_WSTRB_EN
    chk("strb_merge", regs_o[95:64], 32'hFF00_FF00);
`else
    chk("strb_ignored", regs_o[95:64], 32'h0);
`endif
    axi_read(32'h08, 0);

    // Same-edge read and write of register 3: the read returns the old contents.
    re.resp = 2'b00; re.data = model[3];
    rq.push_back(re);
    model_write(32'h0C, 32'h7777_0000, 4'hF);
    aw_addr = 32'h0C; w_data = 32'h7777_0000; w_strb = 4'hF; ar_addr = 32'h0C;
    aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1; b_ready = 1'b1; r_ready = 1'b1;
    @(posedge clk); #1;
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    for (int i = 0; i < 10 && (bq.size() != 0 || rq.size() != 0 || pq.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    b_ready = 1'b0; r_ready = 1'b0;
    chk("concurrent_drain", 32'(bq.size() + rq.size()), 32'd0);

    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, NUM_REGS*4 + 15));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
      else begin
        status_i = $urandom;
        axi_read(a, int'($urandom_range(0, 3)));
      end
    end

    // Reset with an AW beat already captured: the transaction is dropped.
    aw_addr = 32'h18; aw_valid = 1'b1;
    @(posedge clk); #1;
    aw_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chkw("midrst_regs", regs_o, '0);
    chk("midrst_ready", {29'd0, aw_ready, w_ready, ar_ready}, 32'd7);
    chk("midrst_b_valid", 32'(b_valid), 32'd0);
    chk("midrst_wr_idx", 32'(wr_idx_o), 32'd0);
    for (int i = 0; i < NUM_REGS; i++) model[i] = 32'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_b", 32'(b_valid), 32'd0);
      @(posedge clk); #1;
    end
    axi_write(32'h18, 32'h0BAD_F00D, 4'hF, 2, 1);
    axi_read(32'h18, 1);

    repeat (3) @(posedge clk);
    chk("queues_empty", 32'(bq.size() + rq.size() + pq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axil_reg_responder.md
# axil_reg_responder

AXI-Lite responder that terminates the 32-bit AXI-Lite port driven by the host-side initiator and exposes a bank of control/status registers to the banzAI core. It handles the write (AW/W/B) and read (AR/R) channels independently, with one outstanding transaction per channel. Register contents drive the core through a flat output bus; the core writes back status through a flat input bus.

## Interface
- `NUM_REGS`, 16: number of 32-bit registers; power of two, 2..256.
- `ID_VALUE`, 32'hBA5A_0001: read-only contents of register 0.
- `clk` in 1: single clock; all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `aw_addr` in 32: write address, byte-addressed.
- `aw_valid` in 1 / `aw_ready` out 1: write-address handshake.
- `w_data` in 32: write data.
- `w_strb` in 4: byte-lane strobes (see Configuration).
- `w_valid` in 1 / `w_ready` out 1: write-data handshake.
- `b_resp` out 2: write response, 2'b00 OKAY, 2'b10 SLVERR.
- `b_valid` out 1 / `b_ready` in 1: write-response handshake.
- `ar_addr` in 32: read address, byte-addressed.
- `ar_valid` in 1 / `ar_ready` out 1: read-address handshake.
- `r_data` out 32, `r_resp` out 2: read data and response.
- `r_valid` out 1 / `r_ready` in 1: read-data handshake.
- `regs_o` out NUM_REGS*32: register contents, register i at bits [32i+31:32i].
- `status_i` in 32: sampled live when register 1 is read.
- `wr_pulse_o` out 1, `wr_idx_o` out $clog2(NUM_REGS): one-cycle pulse and index on every successful register write.

## Operation
- Word index = addr[$clog2(NUM_REGS)+1:2]; addr[1:0] ignored. Address ≥ NUM_REGS*4 is out of range.
- Register 0: read-only, returns ID_VALUE. Register 1: read-only, returns status_i. Registers 2..NUM_REGS-1: read/write. regs_o slices 0 and 1 drive 0.
- Write to register 0/1 or out of range: no state change, no wr_pulse_o, b_resp = 2'b10. Read out of range: r_data = 0, r_resp = 2'b10. All other accesses respond 2'b00.
- Write FSM: W_IDLE -> W_RESP -> W_IDLE.
  - In W_IDLE, aw_ready = 1 until an AW beat is captured; w_ready = 1 until a W beat is captured. AW and W may arrive in the same cycle or in either order, any gap apart.
  - At the edge on which both beats are held: commit the write, set b_valid, enter W_RESP. aw_ready = w_ready = 0 in W_RESP.
  - W_RESP -> W_IDLE on the edge with b_valid && b_ready; both capture flags cleared.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - ar_ready = 1 in R_IDLE. On the handshake edge, latch r_data/r_resp, set r_valid, enter R_DATA.
  - r_data/r_resp held stable until the r_valid && r_ready edge, then back to R_IDLE.
- Simultaneous read and write commit to the same register: read returns the pre-write value.

## Timing
- Reset values: aw_ready = w_ready = ar_ready = 1; b_valid = r_valid = 0; b_resp = r_resp = 2'b00; r_data = 0; all registers 0; wr_pulse_o = 0; wr_idx_o = 0.
- Write: b_valid rises the cycle after the last of the AW/W handshakes. regs_o and wr_pulse_o update in that same cycle.
- Read: r_valid rises the cycle after the AR handshake.
- Back-to-back: the next AW/W/AR is accepted the cycle after the B/R handshake.
- b_valid and r_valid never drop without the matching ready.
- Reset asserted mid-transaction: all state returns to reset values immediately, and the in-flight transaction is dropped.

## Configuration
- `AXIL_WSTRB_EN` defined: only byte lanes with w_strb[k] = 1 are written. w_strb = 0 is treated as a successful no-op write (OKAY, wr_pulse_o still asserted).
- `AXIL_WSTRB_EN` undefined: w_strb is ignored and every write updates the full 32-bit word.

## Test plan
- Write 0x08 <- 32'hCAFE_BABE, then read 0x08 -> b_resp 2'b00, r_data 32'hCAFE_BABE, regs_o[95:64] = 32'hCAFE_BABE, one wr_pulse_o with wr_idx_o = 2.
- Read 0x00 -> ID_VALUE. Read 0x04 with status_i = 32'h1234 -> 32'h1234. Write 0x00 -> b_resp 2'b10, read 0x00 still returns ID_VALUE.
- With NUM_REGS = 16, write 0x40 <- 1 -> b_resp 2'b10, no wr_pulse_o; read 0x40 -> r_data 0, r_resp 2'b10.
- AW at 0x0C, then W (32'h5) 3 cycles later -> aw_ready low after capture, b_valid one cycle after W handshake, reg 3 = 5. Repeat with W first.
- b_ready and r_ready held low for 5 cycles -> b_valid/r_valid and their payloads stay stable; ar_ready stays 0 and aw_ready/w_ready stay 0 throughout.
- `AXIL_WSTRB_EN` defined: reg 2 = 32'hFFFF_FFFF, write 0x08 <- 32'h0, w_strb = 4'b0101 -> reg 2 = 32'hFF00_FF00. Undefined: same stimulus -> 32'h0.
